hazard_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage RISC-V pipeline. Drives the

---
 rtl/hazard_ctrl_if.sv | 41 ++++
 rtl/hazard_ctrl.sv | 108 ++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the stall/flush
// sequencer: hazard-detection inputs from ID/EX and the per-stage control
// outputs plus performance counters.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic             ex_md_start;
  logic             md_done;
  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_stall;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             md_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Pipeline side: supplies hazard information, consumes stall/flush controls.
  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    output ex_rd, ex_mem_read, ex_branch_taken, ex_md_start, md_done,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
    input  ex_mem_flush, md_timeout, stall_cnt, flush_cnt
  );

  // Sequencer side.
  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    input  ex_rd, ex_mem_read, ex_branch_taken, ex_md_start, md_done,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
    output ex_mem_flush, md_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Resolves load-use
// hazards, taken redirects and multi-cycle MUL/DIV occupancy of EX, and keeps
// saturating stall/flush event counters. Control outputs are combinational.
module hazard_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);
  localparam int TMR_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MD_TIMEOUT - 1);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] md_timer;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             load_use;
  logic             pc_stall, if_id_stall, if_id_flush;
  logic             id_ex_stall, id_ex_flush, ex_mem_flush, md_timeout;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Load in EX whose destination feeds a source the ID instruction reads.
  assign load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                    ((hz.id_rs1_used && (hz.id_rs1 == hz.ex_rd)) ||
                     (hz.id_rs2_used && (hz.id_rs2 == hz.ex_rd)));

  // Next-state and stall/flush decode; a redirect beats load-use because the
  // instruction in ID is on the wrong path and gets flushed anyway.
  always_comb begin
    state_nxt    = state;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    md_timeout   = 1'b0;
    case (state)
      RUN: begin
        if (hz.ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (load_use) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
        end
        if (hz.ex_md_start && !hz.md_done) state_nxt = MD_BUSY;
      end
      MD_BUSY: begin
        if (hz.md_done) begin
          state_nxt = RUN;
        end else if (md_timer == TMR_LAST) begin
          state_nxt  = RUN;
          md_timeout = 1'b1;
        end else begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_stall  = 1'b1;
          ex_mem_flush = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // MUL/DIV occupancy timer: held at zero in RUN so every entry starts fresh.
  always_ff @(posedge clk) begin
    if (rst || (state == RUN)) md_timer <= '0;
    else                       md_timer <= md_timer + TMR_W'(1);
  end

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_stall)    stall_cnt <= sat_inc(stall_cnt);
      if (if_id_flush) flush_cnt <= sat_inc(flush_cnt);
    end
  end

  assign hz.pc_stall     = pc_stall;
  assign hz.if_id_stall  = if_id_stall;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_stall  = id_ex_stall;
  assign hz.id_ex_flush  = id_ex_flush;
  assign hz.ex_mem_flush = ex_mem_flush;
  assign hz.md_timeout   = md_timeout;
  assign hz.stall_cnt    = stall_cnt;
  assign hz.flush_cnt    = flush_cnt;
endmodule
